// File: rtl/memctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : memctrl_if
// Purpose  : Groups the request/response and RAM bus signals of the memory
//            controller. The "slave" modport is the controller's view and
//            "master" is the environment's view (LSB, fetch unit, RAM).
// Signals  :
//   rdy              global pause (1 = run)
//   rollback         misprediction flush
//   load_store_sgn   LSB request strobe
//   load_or_store    1 = load, 0 = store
//   load_store_op    5-bit op code
//   load_store_addr  byte address of the LSB request
//   load_store_data  store data (low bytes used)
//   mem_valid        one-cycle LSB completion pulse
//   mem_res          extended load result
//   if_req           fetch request strobe
//   if_addr          fetch address
//   if_valid         one-cycle fetch completion pulse
//   if_inst          fetched instruction word
//   mem_din          RAM read byte
//   mem_dout         RAM write byte
//   mem_a            RAM byte address
//   mem_wr           RAM write enable for this cycle
//   io_buffer_full   IO write buffer full
// Revision : 1.0  initial release
// ============================================================================
interface memctrl_if;
  logic        rdy;
  logic        rollback;
  logic        load_store_sgn;
  logic        load_or_store;
  logic [4:0]  load_store_op;
  logic [31:0] load_store_addr;
  logic [31:0] load_store_data;
  logic        mem_valid;
  logic [31:0] mem_res;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  rdy, rollback, load_store_sgn, load_or_store, load_store_op,
           load_store_addr, load_store_data, if_req, if_addr, mem_din,
           io_buffer_full,
    output mem_valid, mem_res, if_valid, if_inst, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, rollback, load_store_sgn, load_or_store, load_store_op,
           load_store_addr, load_store_data, if_req, if_addr, mem_din,
           io_buffer_full,
    input  mem_valid, mem_res, if_valid, if_inst, mem_dout, mem_a, mem_wr
  );
endinterface
`default_nettype wire

// File: rtl/memctrl.sv
`default_nettype none
// ============================================================================
// Module   : memctrl
// Purpose  : Serialises LSB load/store requests and instruction fetches into
//            single-byte transactions on a byte-wide synchronous RAM,
//            reassembles/extends read data and returns it with a one-cycle
//            valid pulse. Sole driver of the RAM bus.
// Ports    :
//   clk      clock
//   rst_n    asynchronous active-low reset
//   bus      memctrl_if.slave (requests, responses, RAM bus, rdy/rollback)
// Params   :
//   IO_BASE  base of the IO window; addr[17:16] matching IO_BASE[17:16] is IO
// Config   :
//   MEMCTRL_IO_STALL_EN  when defined, a write to an IO address is held
//                        (mem_wr=0) while io_buffer_full is high. When not
//                        defined io_buffer_full is ignored.
// Revision : 1.0  initial release
// ============================================================================
module memctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input wire        clk,
  input wire        rst_n,
  memctrl_if.slave  bus
);

  localparam logic [4:0] OP_LB  = 5'd0;
  localparam logic [4:0] OP_LH  = 5'd1;
  localparam logic [4:0] OP_LW  = 5'd2;
  localparam logic [4:0] OP_LBU = 5'd3;
  localparam logic [4:0] OP_LHU = 5'd4;
  localparam logic [4:0] OP_SB  = 5'd5;
  localparam logic [4:0] OP_SH  = 5'd6;
  localparam logic [4:0] OP_SW  = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  function automatic logic [2:0] f_len(input logic [4:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: f_len = 3'd1;
      OP_LH, OP_LHU, OP_SH: f_len = 3'd2;
      default:              f_len = 3'd4;
    endcase
  endfunction

  state_t      r_state;
  // pending request slots
  logic        r_ls_vld, r_ls_load;
  logic [4:0]  r_ls_op;
  logic [31:0] r_ls_addr, r_ls_data;
  logic        r_if_vld;
  logic [31:0] r_if_addr;
  // active transaction
  logic        r_cur_if;
  logic [4:0]  r_cur_op;
  logic [31:0] r_base, r_data, r_buf;
  logic [2:0]  r_len;
  logic [2:0]  r_rd_idx;   // byte index whose address is on mem_a
  logic [2:0]  r_smp_idx;  // byte index expected on mem_din this cycle
  logic        r_smp_vld;
  logic        r_stale;    // a pause hit a read; mem_din no longer lines up
  // registered outputs
  logic [31:0] r_mem_a;
  logic [7:0]  r_dout;
  logic        r_wr;
  logic        r_mem_valid, r_if_valid;
  logic [31:0] r_mem_res, r_if_inst;

  // A strobe in the current cycle is visible to IDLE directly, so a request
  // from idle puts its first address on the bus in the very next cycle.
  logic        w_ls_take, w_if_take, w_ls_req, w_if_req;
  logic        w_ls_load;
  logic [4:0]  w_ls_op;
  logic [31:0] w_ls_addr, w_ls_data, w_fe_addr;
  logic        w_st_go, w_st_if, w_st_load;
  logic [31:0] w_st_addr;
  logic [2:0]  w_st_len;

  assign w_ls_take = bus.load_store_sgn & bus.rdy;
  assign w_if_take = bus.if_req & bus.rdy;
  assign w_ls_req  = r_ls_vld | w_ls_take;
  assign w_if_req  = r_if_vld | w_if_take;
  assign w_ls_load = w_ls_take ? bus.load_or_store   : r_ls_load;
  assign w_ls_op   = w_ls_take ? bus.load_store_op   : r_ls_op;
  assign w_ls_addr = w_ls_take ? bus.load_store_addr : r_ls_addr;
  assign w_ls_data = w_ls_take ? bus.load_store_data : r_ls_data;
  assign w_fe_addr = w_if_take ? bus.if_addr         : r_if_addr;
  assign w_st_go   = w_ls_req | w_if_req;
  assign w_st_if   = ~w_ls_req;
  assign w_st_load = w_st_if | w_ls_load;
  assign w_st_addr = w_st_if ? w_fe_addr : w_ls_addr;
  assign w_st_len  = w_st_if ? 3'd4 : f_len(w_ls_op);

  logic [2:0]  w_nxt_idx, w_re_idx;
  logic [31:0] w_asm, w_ext;
  logic        w_stall, w_wr_ok;

  assign w_nxt_idx = r_rd_idx + 3'd1;
  assign w_re_idx  = r_smp_vld ? r_smp_idx : r_rd_idx;

`ifdef MEMCTRL_IO_STALL_EN
  logic w_io_addr;
  assign w_io_addr = (r_mem_a[17:16] == IO_BASE[17:16]);
  assign w_stall   = bus.io_buffer_full & w_io_addr;
`else
  logic w_unused_io;
  assign w_unused_io = bus.io_buffer_full;
  assign w_stall     = 1'b0;
`endif

  // The RAM only sees a write in a cycle where the controller is running and
  // the target can accept it; a held write byte retries in the next cycle.
  assign w_wr_ok = r_wr & bus.rdy & ~w_stall;

  // Buffered bytes with the incoming byte merged at its lane.
  always_comb begin
    w_asm = r_buf;
    for (int i = 0; i < 4; i++) begin
      if (r_smp_idx == 3'(i)) w_asm[8*i +: 8] = bus.mem_din;
    end
  end

  always_comb begin
    w_ext = w_asm;
    case (r_cur_op)
      OP_LB:   w_ext = {{24{w_asm[7]}}, w_asm[7:0]};
      OP_LH:   w_ext = {{16{w_asm[15]}}, w_asm[15:0]};
      OP_LBU:  w_ext = {24'd0, w_asm[7:0]};
      OP_LHU:  w_ext = {16'd0, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ls_vld    <= 1'b0;
      r_ls_load   <= 1'b0;
      r_ls_op     <= 5'd0;
      r_ls_addr   <= 32'd0;
      r_ls_data   <= 32'd0;
      r_if_vld    <= 1'b0;
      r_if_addr   <= 32'd0;
      r_cur_if    <= 1'b0;
      r_cur_op    <= 5'd0;
      r_base      <= 32'd0;
      r_data      <= 32'd0;
      r_buf       <= 32'd0;
      r_len       <= 3'd0;
      r_rd_idx    <= 3'd0;
      r_smp_idx   <= 3'd0;
      r_smp_vld   <= 1'b0;
      r_stale     <= 1'b0;
      r_mem_a     <= 32'd0;
      r_dout      <= 8'd0;
      r_wr        <= 1'b0;
      r_mem_valid <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_res   <= 32'd0;
      r_if_inst   <= 32'd0;
    end else if (!bus.rdy) begin
      // Everything holds; remember that an in-flight read lost its alignment
      // with the RAM's registered output.
      if (r_state == S_READ) r_stale <= 1'b1;
    end else begin
      r_mem_valid <= 1'b0;
      r_if_valid  <= 1'b0;

      if (w_ls_take) begin
        r_ls_vld  <= 1'b1;
        r_ls_load <= bus.load_or_store;
        r_ls_op   <= bus.load_store_op;
        r_ls_addr <= bus.load_store_addr;
        r_ls_data <= bus.load_store_data;
      end
      if (w_if_take) begin
        r_if_vld  <= 1'b1;
        r_if_addr <= bus.if_addr;
      end
      if (bus.rollback) begin
        r_ls_vld <= 1'b0;
        r_if_vld <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_st_go && !bus.rollback) begin
            if (w_st_if) r_if_vld <= 1'b0;
            else         r_ls_vld <= 1'b0;
            r_cur_if  <= w_st_if;
            r_cur_op  <= w_ls_op;
            r_base    <= w_st_addr;
            r_data    <= w_ls_data;
            r_len     <= w_st_len;
            r_mem_a   <= w_st_addr;
            r_buf     <= 32'd0;
            r_rd_idx  <= 3'd0;
            r_smp_vld <= 1'b0;
            r_stale   <= 1'b0;
            if (w_st_load) begin
              r_state <= S_READ;
            end else begin
              r_state <= S_WRITE;
              r_wr    <= 1'b1;
              r_dout  <= w_ls_data[7:0];
            end
          end
        end

        S_READ: begin
          if (bus.rollback) begin
            r_state   <= S_IDLE;
            r_smp_vld <= 1'b0;
          end else if (r_stale) begin
            // Re-issue the oldest unsampled address and restart the pipe.
            r_stale   <= 1'b0;
            r_smp_vld <= 1'b0;
            r_rd_idx  <= w_re_idx;
            r_mem_a   <= r_base + {29'd0, w_re_idx};
          end else begin
            if (r_smp_vld) begin
              r_buf <= w_asm;
              if (r_smp_idx == r_len - 3'd1) begin
                r_state <= S_IDLE;
                if (r_cur_if) begin
                  r_if_inst  <= w_asm;
                  r_if_valid <= 1'b1;
                end else begin
                  r_mem_res   <= w_ext;
                  r_mem_valid <= 1'b1;
                end
              end
            end
            r_smp_idx <= r_rd_idx;
            r_smp_vld <= (r_rd_idx < r_len);
            if (r_rd_idx < r_len) begin
              r_rd_idx <= w_nxt_idx;
              // Last address stays on the bus rather than running past the end.
              if (w_nxt_idx < r_len) r_mem_a <= r_base + {29'd0, w_nxt_idx};
            end
          end
        end

        S_WRITE: begin
          // Rollback is deliberately ignored here so a store is never torn.
          if (w_wr_ok) begin
            if (r_rd_idx == r_len - 3'd1) begin
              r_wr        <= 1'b0;
              r_mem_valid <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rd_idx <= w_nxt_idx;
              r_mem_a  <= r_base + {29'd0, w_nxt_idx};
              r_dout   <= r_data[{w_nxt_idx[1:0], 3'b000} +: 8];
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_res   = r_mem_res;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_inst   = r_if_inst;
  assign bus.mem_a     = r_mem_a;
  assign bus.mem_dout  = r_dout;
  assign bus.mem_wr    = w_wr_ok;

endmodule
`default_nettype wire

// File: doc/memctrl.md
# memctrl

Memory controller between the load/store buffer, instruction fetch and the byte-wide unified RAM. It responds to the LSB's one-shot load/store requests and fetch requests, serialises them into single-byte RAM transactions, reassembles or sign-extends results, and returns them with a one-cycle valid pulse. It is the only driver of the RAM bus.

## Interface
- `IO_BASE`, default 32'h0003_0000: addresses with `addr[17:16]==2'b11` are IO (stall-sensitive).
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rdy`  in  1  global pause; when low all state holds, RAM bus `mem_wr` forced 0.
- `rollback`  in  1  misprediction flush.
- `load_store_sgn`  in  1  LSB request strobe.
- `load_or_store`  in  1  1 = load, 0 = store.
- `load_store_op`  in  5  op code (`LB`,`LH`,`LW`,`LBU`,`LHU`,`SB`,`SH`,`SW` from defines.v).
- `load_store_addr`  in  32  byte address.
- `load_store_data`  in  32  store data (low bytes used).
- `mem_valid`  out  1  one-cycle completion pulse for LSB.
- `mem_res`  out  32  load result, extended per op.
- `if_req`  in  1  fetch request strobe.
- `if_addr`  in  32  fetch address (word aligned).
- `if_valid`  out  1  one-cycle fetch completion pulse.
- `if_inst`  out  32  fetched instruction word.
- `mem_din`  in  8  RAM read byte.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  1 = write this cycle.
- `io_buffer_full`  in  1  IO write buffer full.

## Operation
- One pending slot per requester; strobe high with `rdy` latches that requester's fields (new strobe overwrites an unserviced slot).
- States: IDLE, READ, WRITE. In IDLE, LSB slot has priority over fetch slot; selected slot cleared on start.
- Length: byte ops 1, half 2, word/fetch 4. Bytes little-endian, address `base+i` for byte i.
- READ: issue byte i address on cycle i; byte for address issued in cycle k sampled at end of cycle k+1. After last sample: assemble, extend (`LB`/`LH` sign, `LBU`/`LHU` zero), pulse `mem_valid` or `if_valid` next cycle, return to IDLE.
- WRITE: one byte per cycle, `mem_wr=1`, `mem_dout=data[8i+7:8i]`; after last byte pulse `mem_valid`, return to IDLE.
- IO stall: write to IO address while `io_buffer_full`=1 → hold byte, `mem_wr=0`, retry next cycle.
- Rollback: both slots cleared; in-flight READ aborts next edge (no valid pulse, `mem_wr` stays 0); in-flight WRITE completes and pulses `mem_valid` (no torn stores).
- Unaligned addresses accepted; no alignment check.

## Timing
- Reset: `mem_valid`=0, `mem_res`=0, `if_valid`=0, `if_inst`=0, `mem_a`=0, `mem_dout`=0, `mem_wr`=0, state IDLE, slots empty.
- Reset asserted mid-transaction: immediate return to IDLE, no pulse.
- LW from IDLE, strobe in cycle 0: addresses cycles 1–4, samples end of 2–5, `mem_valid` in cycle 6. LB: `mem_valid` cycle 3.
- SW: writes cycles 1–4, `mem_valid` cycle 5. SB: `mem_valid` cycle 2.
- Back-to-back: next request starts cycle after valid pulse.
- `mem_res`/`if_inst` hold until next completion of the same requester.
- `rdy`=0: counters, addresses, state frozen; a sample due during pause is retaken after resume (address reissued first).

## Configuration
- `MEMCTRL_IO_STALL_EN` defined: IO stall rule above active.
- Undefined: `io_buffer_full` ignored; writes never stall.

## Test plan
- LW addr 0x100, RAM bytes 0x11,0x22,0x33,0x44 → `mem_valid` cycle 6, `mem_res`=0x44332211.
- LB 0x80 then LBU 0x80 → `mem_res`=0xFFFFFF80 then 0x00000080.
- SH 0x204 data 0xABCD1234 → `mem_wr` 2 cycles, (0x204,0x34),(0x205,0x12); `mem_valid` cycle 3.
- LSB and fetch strobed same cycle → load completes first, `if_valid` after fetch's 4 reads.
- Rollback during fetch byte 2 → no `if_valid`; rollback during SW → all 4 bytes written, `mem_valid` pulses.
- With `MEMCTRL_IO_STALL_EN`: SB to 0x30000, `io_buffer_full`=1 for 3 cycles → `mem_wr` first high cycle 4, `mem_valid` cycle 5.
